// File: rtl/mdv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mdv_issue_ctrl
//
// Issue controller between the execute stage and the multiply/divide unit.
// Multiply, divide and move-to-HI/LO requests are buffered in a small in-order
// queue. The head entry is sent to the MDV only when the unit is free. The
// controller tracks in-flight latency itself, so mfhi/mflo reads are admitted
// only once HI/LO hold the architectural result. A flush discards queued work
// that has not issued yet.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   req_valid  request present
//   req_op     0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo
//   req_a/b    operands (req_b unused by mt*)
//   req_ready  request accepted when req_valid && req_ready
//   flush      drop queued entries and the request offered this cycle
//   mdv_start  one-cycle start strobe, arithmetic ops only
//   mdv_op     MDV operation code (see MDV_* below), MDV_NONE when idle
//   mdv_a/b    operands to the MDV, zero when idle (mdv_b is zero for mt*)
//   mdv_busy   MDV busy flag
//   rd_stall   a valid mf* request is being held
//   pend_cnt   queued entries, excluding the op in flight
//
// MDV operation encoding on mdv_op:
//   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo
// -----------------------------------------------------------------------------
module mdv_issue_ctrl #(
  parameter int DEPTH    = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [2:0]               req_op,
  input  logic [31:0]              req_a,
  input  logic [31:0]              req_b,
  output logic                     req_ready,
  input  logic                     flush,
  output logic                     mdv_start,
  output logic [3:0]               mdv_op,
  output logic [31:0]              mdv_a,
  output logic [31:0]              mdv_b,
  input  logic                     mdv_busy,
  output logic                     rd_stall,
  output logic [$clog2(DEPTH):0]   pend_cnt
);

  localparam int PW      = $clog2(DEPTH);
  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 2);

  localparam logic [3:0] MDV_NONE = 4'd0;

  // Request codes 0..7 map onto MDV codes 1..8, leaving 0 for "none".
  function automatic logic [3:0] op_code(input logic [2:0] op);
    return {1'b0, op} + 4'd1;
  endfunction

  // Queue storage and state
  logic [2:0]       op_mem [DEPTH];
  logic [31:0]      a_mem  [DEPTH];
  logic [31:0]      b_mem  [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [CW-1:0]    inflight_q, inflight_d;

  logic             full, empty, unit_free;
  logic             req_is_rd, enq, issue, rd_accept;
  logic [2:0]       head_op;
  logic             head_arith;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    full       = (cnt_q == (PW+1)'(DEPTH));
    empty      = (cnt_q == '0);
    unit_free  = (inflight_q == '0) && !mdv_busy;
    req_is_rd  = (req_op[2:1] == 2'b11);

    // Arithmetic/mt* readiness is purely !full; it never looks at a
    // same-cycle issue, which keeps req_ready off the issue path.
    req_ready  = req_is_rd ? (empty && unit_free) : !full;
    rd_stall   = req_valid && req_is_rd && !req_ready;
    rd_accept  = req_valid && req_is_rd && req_ready;
    enq        = req_valid && !req_is_rd && !full && !flush;

    // Issue only looks at registered queue state: no bypass of a request
    // arriving this cycle.
    issue      = !empty && unit_free;
    head_op    = op_mem[rd_ptr_q];
    head_arith = !head_op[2];

    mdv_start  = 1'b0;
    mdv_op     = MDV_NONE;
    mdv_a      = '0;
    mdv_b      = '0;
    if (issue) begin
      mdv_start = head_arith;
      mdv_op    = op_code(head_op);
      mdv_a     = a_mem[rd_ptr_q];
      mdv_b     = head_arith ? b_mem[rd_ptr_q] : '0;
    end else if (rd_accept) begin
      mdv_op    = op_code(req_op);
    end

    wr_ptr_d = wr_ptr_q + PW'(enq);
    rd_ptr_d = rd_ptr_q + PW'(issue);
    cnt_d    = cnt_q + (PW+1)'(enq) - (PW+1)'(issue);
    if (flush) begin
      // An issue this cycle still happens (outputs above); only the
      // remaining queued entries are dropped.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end

    // The extra cycle on arithmetic ops covers the HI/LO write after busy
    // falls; mt* needs one cycle for its write to become visible.
    inflight_d = inflight_q;
    if (issue) begin
      unique case (head_op[2:1])
        2'b00:   inflight_d = CW'(MULT_CYC + 1);
        2'b01:   inflight_d = CW'(DIV_CYC + 1);
        default: inflight_d = CW'(1);
      endcase
    end else if (inflight_q != '0) begin
      inflight_d = inflight_q - CW'(1);
    end
  end

  assign pend_cnt = cnt_q;

  // NOTE: queue storage has no reset; an entry is only read after it has
  // been written, and the valid count alone defines occupancy.
  always_ff @(posedge clk) begin
    if (enq) begin
      op_mem[wr_ptr_q] <= req_op;
      a_mem[wr_ptr_q]  <= req_a;
      b_mem[wr_ptr_q]  <= req_b;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      inflight_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: doc/mdv_issue_ctrl.md
# mdv_issue_ctrl

Issue controller between the execute stage and the multiply/divide unit (MDV). It buffers multiply, divide and move-to-HI/LO requests in a small in-order queue and issues each one to the MDV only when the unit is free. It tracks the in-flight latency itself, so HI/LO reads (mfhi/mflo) are admitted only once the result is architecturally visible. It also discards queued, not-yet-issued work on a pipeline flush.

## Interface
Parameters:
- DEPTH, 2: queue entries, power of two, ≥2.
- MULT_CYC, 5: MDV busy cycles for mult/multu.
- DIV_CYC, 10: MDV busy cycles for div/divu.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_op  in  3  request code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo.
- req_a, req_b  in  32  operands; req_b is ignored for mt*.
- req_ready  out  1  a request is accepted when req_valid && req_ready.
- flush  in  1  discard queued entries and the request offered this cycle.
- mdv_start  out  1  one-cycle start strobe to the MDV, arithmetic ops only.
- mdv_op  out  MDVOPTION  operation to the MDV; MDV_none when idle.
- mdv_a, mdv_b  out  32  operands to the MDV.
- mdv_busy  in  1  MDV busy flag.
- rd_stall  out  1  a valid mf* request is being held.
- pend_cnt  out  $clog2(DEPTH)+1  number of queued entries, excluding the in-flight op.

## Operation
- Queue: FIFO holding op/a/b with wrapping read and write pointers. Full when pend_cnt==DEPTH.
- Enqueue: ops 0–5 are accepted when the queue is not full.
  - The arithmetic req_ready path is !full. It does not depend on an issue in the same cycle.
- Read ops (6, 7) never enter the queue. They are accepted only when all of the following hold: queue empty, inflight==0, !mdv_busy.
  - In the accept cycle, mdv_op = MDV_mfhi/MDV_mflo (combinational) and mdv_start=0. The pipeline samples MDVans in that cycle.
  - rd_stall = req_valid && req_op∈{6,7} && !req_ready.
- Issue: the head entry issues when all of the following hold: queue not empty, inflight==0, !mdv_busy.
  - Arithmetic issue: mdv_start=1, mdv_op=head op, mdv_a/mdv_b=head operands, all for exactly one cycle.
  - inflight counter loads MULT_CYC+1 (mult/multu) or DIV_CYC+1 (div/divu). The +1 covers the HI/LO write cycle after busy falls.
  - mt* issue: mdv_start=0, mdv_op=MDV_mthi/MDV_mtlo for one cycle, mdv_a=operand; inflight loads 1.
  - The issue decision is registered, so an entry enqueued into an empty queue issues in the next cycle at the earliest. There is no bypass.
- inflight counter: decrements to 0 each cycle it is nonzero.
- Idle outputs: whenever neither an issue nor a read is in progress, mdv_op=MDV_none, mdv_start=0, mdv_a=mdv_b=0. The MDV treats mt* ops as writes every cycle they are present, so no stale op may be held.
- Flush:
  - Queue pointers are reset and pend_cnt becomes 0 at the next edge.
  - A request offered in the flush cycle is not enqueued. req_ready may be high, but the request has no effect.
  - An issue in the flush cycle still takes place, and an op already in flight completes.
  - inflight is not cleared, so following reads still wait for completion.
- Simultaneous enqueue and issue in the same cycle: pend_cnt stays unchanged.
- Reset:
  - Queue empty, pend_cnt=0, inflight=0.
  - mdv_start=0, mdv_op=MDV_none, mdv_a=mdv_b=0.
  - req_ready=1 for ops 0–5; rd_stall follows its equation.
  - Reset mid-operation abandons the in-flight count; the MDV is reset by the same signal.

## Timing
- Issue to mf* admission, mult: start in cycle N, MDV busy high N+1..N+MULT_CYC, read admitted at N+MULT_CYC+2 at the earliest.
- Issue to mf* admission, div: the same, using DIV_CYC.
- mt* issue in cycle N: read admitted at N+2 at the earliest.
- Back-to-back arithmetic ops are spaced by full latency plus one, e.g. a second mult starts at N+MULT_CYC+2.
- Stall persistence: if mdv_busy is high while inflight==0 (unexpected), issue and reads both stall until it drops.

## Test plan
- Single mult:
  - Stimulus: enqueue mult A=3, B=-4; then mflo offered continuously.
  - Required: mdv_start pulses one cycle later; rd_stall high until start+7; mflo accepted at start+7 with MDVans=0xFFFFFFF4.
- Queue full:
  - Stimulus: enqueue div, divu, mult back-to-back (DEPTH=2).
  - Required: third request gets req_ready=0 until the first entry issues; issue order div, divu, mult; starts at cycle S, S+12, S+24.
- mt then read:
  - Stimulus: mthi 0x12345678, then mfhi.
  - Required: mdv_op=MDV_mthi for exactly one cycle; mfhi returns 0x12345678 two cycles after the mthi issue.
- Flush:
  - Stimulus: mult issued, two entries queued; flush asserted together with a new mtlo request.
  - Required: pend_cnt=0 next cycle; mtlo never reaches the MDV; mult completes; mflo returns the mult low word.
- Reset mid-divide:
  - Stimulus: reset asserted at start+3 of a div.
  - Required: the next cycle has pend_cnt=0, mdv_op=MDV_none, req_ready=1; a new mult issues normally.
- Simultaneous enqueue and issue:
  - Stimulus: with one entry queued, enqueue a second entry in the cycle the first issues.
  - Required: pend_cnt stays 1.
